// File: rtl/lem_dma_fetch.sv
// LEM1802-style display fetch engine: HWI-mapped bases, once-per-frame DMA refresh of local buffers.
// Build option LEM_FONT_PAL_FETCH_EN adds the font and palette regions; without it only the screen is fetched.
module lem_dma_fetch #(
    parameter int SCREEN_WORDS = 384,
    parameter int FONT_WORDS   = 256,
    parameter int PAL_WORDS    = 16,
    parameter int ADDR_W       = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              hwi_valid,
    input  logic [ADDR_W-1:0] hwi_a,
    input  logic [ADDR_W-1:0] hwi_b,
    input  logic              frame_start,
    output logic              dma_req,
    output logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_gnt,
    input  logic              dma_valid,
    input  logic [ADDR_W-1:0] dma_q,
    output logic              buf_wren,
    output logic [1:0]        buf_sel,
    output logic [8:0]        buf_addr,
    output logic [15:0]       buf_data,
    output logic [3:0]        border_colour,
    output logic              busy,
    output logic              pass_done,
    output logic              overrun
);
    localparam int MAX_SF    = (SCREEN_WORDS > FONT_WORDS) ? SCREEN_WORDS : FONT_WORDS;
    localparam int MAX_WORDS = (MAX_SF > PAL_WORDS) ? MAX_SF : PAL_WORDS;
    localparam int CNT_W     = $clog2(MAX_WORDS);

`ifdef LEM_FONT_PAL_FETCH_EN
    typedef enum logic [2:0] {ST_IDLE, ST_SNAP, ST_SCREEN, ST_FONT, ST_PAL, ST_DONE} state_t;
    logic [ADDR_W-1:0] font_base_q, font_base_d, font_shadow_q, font_shadow_d, eff_font;
    logic [ADDR_W-1:0] pal_base_q, pal_base_d, pal_shadow_q, pal_shadow_d, eff_pal;
    logic [1:0]        buf_sel_q, buf_sel_d;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_SNAP, ST_SCREEN, ST_DONE} state_t;
`endif

    state_t            state_q, state_d, follow;
    logic [ADDR_W-1:0] screen_base_q, screen_base_d, screen_shadow_q, screen_shadow_d, eff_screen;
    logic [ADDR_W-1:0] follow_base, cur_base;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next, last_idx;
    logic              waiting_q, waiting_d;
    logic              dma_req_q, dma_req_d;
    logic [ADDR_W-1:0] dma_addr_q, dma_addr_d;
    logic              buf_wren_q, buf_wren_d;
    logic [8:0]        buf_addr_q, buf_addr_d;
    logic [15:0]       buf_data_q, buf_data_d;
    logic [3:0]        border_q, border_d;
    logic              busy_q, busy_d, pass_done_q, pass_done_d, overrun_q, overrun_d;

    always_comb begin
        // SNAP decides the first region from the live bases it is latching into the shadows
        eff_screen = (state_q == ST_SNAP) ? screen_base_q : screen_shadow_q;
        follow     = ST_DONE;
`ifdef LEM_FONT_PAL_FETCH_EN
        eff_font = (state_q == ST_SNAP) ? font_base_q : font_shadow_q;
        eff_pal  = (state_q == ST_SNAP) ? pal_base_q : pal_shadow_q;
        if (state_q != ST_PAL && eff_pal != '0)
            follow = ST_PAL;
        if ((state_q == ST_SNAP || state_q == ST_SCREEN) && eff_font != '0)
            follow = ST_FONT;
`endif
        if (state_q == ST_SNAP && eff_screen != '0)
            follow = ST_SCREEN;

        follow_base = eff_screen;
        cur_base    = screen_shadow_q;
        last_idx    = CNT_W'(SCREEN_WORDS - 1);
`ifdef LEM_FONT_PAL_FETCH_EN
        buf_sel_d = buf_sel_q;
        if (follow == ST_FONT) follow_base = eff_font;
        if (follow == ST_PAL)  follow_base = eff_pal;
        if (state_q == ST_FONT) begin
            cur_base = font_shadow_q;
            last_idx = CNT_W'(FONT_WORDS - 1);
        end
        if (state_q == ST_PAL) begin
            cur_base = pal_shadow_q;
            last_idx = CNT_W'(PAL_WORDS - 1);
        end
`endif
        cnt_next = cnt_q + 1'b1;

        state_d         = state_q;
        screen_base_d   = screen_base_q;
        screen_shadow_d = screen_shadow_q;
`ifdef LEM_FONT_PAL_FETCH_EN
        font_base_d   = font_base_q;
        font_shadow_d = font_shadow_q;
        pal_base_d    = pal_base_q;
        pal_shadow_d  = pal_shadow_q;
`endif
        cnt_d      = cnt_q;
        waiting_d  = waiting_q;
        dma_req_d  = dma_req_q;
        dma_addr_d = dma_addr_q;
        buf_wren_d = 1'b0;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        border_d   = border_q;
        overrun_d  = overrun_q | (frame_start && state_q != ST_IDLE);

        if (hwi_valid) begin
            case (hwi_a)
                ADDR_W'(0): screen_base_d = hwi_b;
`ifdef LEM_FONT_PAL_FETCH_EN
                ADDR_W'(1): font_base_d = hwi_b;
                ADDR_W'(2): pal_base_d  = hwi_b;
`endif
                ADDR_W'(3): border_d = hwi_b[3:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: if (frame_start) state_d = ST_SNAP;
            ST_SNAP: begin
                screen_shadow_d = screen_base_q;
`ifdef LEM_FONT_PAL_FETCH_EN
                font_shadow_d = font_base_q;
                pal_shadow_d  = pal_base_q;
`endif
                cnt_d      = '0;
                waiting_d  = 1'b0;
                state_d    = follow;
                dma_req_d  = (follow != ST_DONE);
                dma_addr_d = follow_base;
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (!waiting_q) begin
                    if (dma_gnt) begin
                        dma_req_d = 1'b0;
                        waiting_d = 1'b1;
                    end
                end else if (dma_valid) begin
                    waiting_d  = 1'b0;
                    buf_wren_d = 1'b1;
                    buf_data_d = dma_q;
                    buf_addr_d = 9'(cnt_q);
`ifdef LEM_FONT_PAL_FETCH_EN
                    buf_sel_d = (state_q == ST_FONT) ? 2'd1 : (state_q == ST_PAL) ? 2'd2 : 2'd0;
`endif
                    if (cnt_q == last_idx) begin
                        cnt_d      = '0;
                        state_d    = follow;
                        dma_req_d  = (follow != ST_DONE);
                        dma_addr_d = follow_base;
                    end else begin
                        cnt_d      = cnt_next;
                        dma_req_d  = 1'b1;
                        dma_addr_d = cur_base + ADDR_W'(cnt_next);
                    end
                end
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        pass_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q         <= ST_IDLE;
            screen_base_q   <= '0;
            screen_shadow_q <= '0;
`ifdef LEM_FONT_PAL_FETCH_EN
            font_base_q   <= '0;
            font_shadow_q <= '0;
            pal_base_q    <= '0;
            pal_shadow_q  <= '0;
            buf_sel_q     <= '0;
`endif
            cnt_q       <= '0;
            waiting_q   <= 1'b0;
            dma_req_q   <= 1'b0;
            dma_addr_q  <= '0;
            buf_wren_q  <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            border_q    <= '0;
            busy_q      <= 1'b0;
            pass_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            screen_base_q   <= screen_base_d;
            screen_shadow_q <= screen_shadow_d;
`ifdef LEM_FONT_PAL_FETCH_EN
            font_base_q   <= font_base_d;
            font_shadow_q <= font_shadow_d;
            pal_base_q    <= pal_base_d;
            pal_shadow_q  <= pal_shadow_d;
            buf_sel_q     <= buf_sel_d;
`endif
            cnt_q       <= cnt_d;
            waiting_q   <= waiting_d;
            dma_req_q   <= dma_req_d;
            dma_addr_q  <= dma_addr_d;
            buf_wren_q  <= buf_wren_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            border_q    <= border_d;
            busy_q      <= busy_d;
            pass_done_q <= pass_done_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef LEM_FONT_PAL_FETCH_EN
    assign buf_sel = buf_sel_q;
`else
    assign buf_sel = 2'b00;
`endif
    assign dma_req       = dma_req_q;
    assign dma_addr      = dma_addr_q;
    assign buf_wren      = buf_wren_q;
    assign buf_addr      = buf_addr_q;
    assign buf_data      = buf_data_q;
    assign border_colour = border_q;
    assign busy          = busy_q;
    assign pass_done     = pass_done_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_lem_dma_fetch.sv
// Directed bench for lem_dma_fetch: DMA responder with a synthetic memory, write monitor, per-scenario tasks.
module tb_lem_dma_fetch;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        hwi_valid = 1'b0;
    logic [15:0] hwi_a = '0, hwi_b = '0;
    logic        frame_start = 1'b0;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_gnt = 1'b0, dma_valid = 1'b0;
    logic [15:0] dma_q = '0;
    logic        buf_wren;
    logic [1:0]  buf_sel;
    logic [8:0]  buf_addr;
    logic [15:0] buf_data;
    logic [3:0]  border_colour;
    logic        busy, pass_done, overrun;

    int n_checks = 0, n_fail = 0;
    bit rnd_dly = 0;
    int unstable = 0, pass_cnt = 0, busy_cyc = 0, req_cyc = 0, first_bad = -1;
    logic [26:0] wr_q[$];
    logic [26:0] exp_q[$];

    lem_dma_fetch dut (
        .CLK(CLK), .RST_N(RST_N), .hwi_valid(hwi_valid), .hwi_a(hwi_a), .hwi_b(hwi_b),
        .frame_start(frame_start), .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt),
        .dma_valid(dma_valid), .dma_q(dma_q), .buf_wren(buf_wren), .buf_sel(buf_sel),
        .buf_addr(buf_addr), .buf_data(buf_data), .border_colour(border_colour),
        .busy(busy), .pass_done(pass_done), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    // Responder: gnt and valid delays are 1 cycle, or 1..5 cycles when rnd_dly is set
    task automatic serve();
        logic [15:0] a;
        int g, v;
        a = dma_addr;
        g = rnd_dly ? int'($urandom_range(1, 5)) : 1;
        v = rnd_dly ? int'($urandom_range(1, 5)) : 1;
        repeat (g) begin
            @(posedge CLK); #1;
            if (!dma_req || dma_addr !== a) unstable++;
        end
        dma_gnt = 1'b1;
        @(posedge CLK); #1;
        dma_gnt = 1'b0;
        repeat (v - 1) begin
            @(posedge CLK); #1;
        end
        dma_valid = 1'b1;
        dma_q = mem_word(a);
    endtask

    initial forever begin
        @(posedge CLK); #1;
        dma_valid = 1'b0;
        if (dma_req) serve();
    end

    always @(negedge CLK) begin
        if (buf_wren) wr_q.push_back({buf_sel, buf_addr, buf_data});
        if (pass_done) pass_cnt++;
        if (busy) busy_cyc++;
        if (dma_req) req_cyc++;
    end

    task automatic clear_stats();
        @(posedge CLK);
        wr_q.delete();
        exp_q.delete();
        unstable = 0; pass_cnt = 0; busy_cyc = 0; req_cyc = 0;
    endtask

    task automatic add_region(input logic [1:0] sel, input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({sel, 9'(i), mem_word(base + 16'(i))});
    endtask

    function automatic int count_bad();
        int bad = 0;
        int n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        first_bad = -1;
        for (int i = 0; i < n; i++)
            if (wr_q[i] !== exp_q[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        bad += (wr_q.size() > exp_q.size()) ? wr_q.size() - exp_q.size() : exp_q.size() - wr_q.size();
        return bad;
    endfunction

    task automatic hwi(input logic [15:0] a, input logic [15:0] b);
        @(negedge CLK);
        hwi_valid = 1'b1; hwi_a = a; hwi_b = b;
        @(negedge CLK);
        hwi_valid = 1'b0;
    endtask

    task automatic start_pass();
        @(negedge CLK);
        frame_start = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit, output bit tmo);
        tmo = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK); #1;
            if (pass_cnt >= target) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge CLK); #1;
        n_checks++;
        if ({dma_req, buf_wren, busy, pass_done, overrun} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {dma_req, buf_wren, busy, pass_done, overrun});
        end
        n_checks++;
        if (dma_addr !== 16'h0 || border_colour !== 4'h0) begin
            n_fail++; $display("FAIL reset_regs: got addr %h border %h want 0000 0", dma_addr, border_colour);
        end
        n_checks++;
        if ({buf_sel, buf_addr, buf_data} !== 27'h0) begin
            n_fail++; $display("FAIL reset_buf: got %h want 0", {buf_sel, buf_addr, buf_data});
        end
        @(negedge CLK);
        RST_N = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_empty_pass();
        clear_stats();
        start_pass(); #1;
        n_checks++;
        if ({busy, pass_done} !== 2'b10) begin
            n_fail++; $display("FAIL empty_snap: got busy,done %b want 10", {busy, pass_done});
        end
        @(negedge CLK); #1;
        n_checks++;
        if ({busy, pass_done} !== 2'b11) begin
            n_fail++; $display("FAIL empty_done: got busy,done %b want 11", {busy, pass_done});
        end
        @(negedge CLK); #1;
        n_checks++;
        if ({busy, pass_done} !== 2'b00) begin
            n_fail++; $display("FAIL empty_idle: got busy,done %b want 00", {busy, pass_done});
        end
        n_checks++;
        if (req_cyc !== 0 || busy_cyc !== 2 || border_colour !== 4'h0) begin
            n_fail++; $display("FAIL empty_stats: got req %0d busy %0d border %h want 0 2 0", req_cyc, busy_cyc, border_colour);
        end
        $display("test_empty_pass done");
    endtask

    task automatic test_screen();
        bit tmo;
        int bad;
        hwi(16'd3, 16'h0005);
        hwi(16'd0, 16'hF000);
        clear_stats();
        add_region(2'd0, 16'hF000, 384);
        start_pass();
        wait_done(1, 3000, tmo);
        bad = count_bad();
        n_checks++;
        if (tmo || bad !== 0) begin
            n_fail++; $display("FAIL screen_writes: got %0d bad (n=%0d first %0d tmo %0b) want 0 of 384", bad, wr_q.size(), first_bad, tmo);
        end
        n_checks++;
        if (busy_cyc !== 2 + 3 * 384 || pass_cnt !== 1 || unstable !== 0) begin
            n_fail++; $display("FAIL screen_timing: got busy %0d done %0d unstable %0d want %0d 1 0", busy_cyc, pass_cnt, unstable, 2 + 3 * 384);
        end
        n_checks++;
        if (border_colour !== 4'h5 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL screen_regs: got border %h overrun %b want 5 0", border_colour, overrun);
        end
        $display("test_screen done: %0d writes", wr_q.size());
    endtask

    task automatic test_wrap();
        bit tmo;
        int bad;
        logic [26:0] e16;
        hwi(16'd0, 16'hFFF0);
        clear_stats();
        add_region(2'd0, 16'hFFF0, 384);
        start_pass();
        wait_done(1, 3000, tmo);
        bad = count_bad();
        n_checks++;
        if (tmo || bad !== 0) begin
            n_fail++; $display("FAIL wrap_writes: got %0d bad (n=%0d first %0d tmo %0b) want 0 of 384", bad, wr_q.size(), first_bad, tmo);
        end
        e16 = (wr_q.size() > 16) ? wr_q[16] : 27'h0;
        n_checks++;
        if (e16 !== {2'd0, 9'd16, mem_word(16'h0000)}) begin
            n_fail++; $display("FAIL wrap_word16: got %h want %h", e16, {2'd0, 9'd16, mem_word(16'h0000)});
        end
        $display("test_wrap done: %0d writes", wr_q.size());
    endtask

    task automatic test_remap_overrun();
        bit tmo;
        int bad;
        hwi(16'd0, 16'h1000);
        clear_stats();
        add_region(2'd0, 16'h1000, 384);
        start_pass();
        repeat (60) @(negedge CLK);
        hwi(16'd0, 16'hA000);
        start_pass();
        wait_done(1, 3000, tmo);
        bad = count_bad();
        n_checks++;
        if (tmo || bad !== 0) begin
            n_fail++; $display("FAIL remap_old_base: got %0d bad (n=%0d first %0d tmo %0b) want 0 of 384", bad, wr_q.size(), first_bad, tmo);
        end
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++; $display("FAIL remap_overrun: got %b want 1", overrun);
        end
        repeat (10) @(negedge CLK); #1;
        n_checks++;
        if (pass_cnt !== 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL remap_no_restart: got passes %0d busy %b want 1 0", pass_cnt, busy);
        end
        clear_stats();
        add_region(2'd0, 16'hA000, 384);
        start_pass();
        wait_done(1, 3000, tmo);
        bad = count_bad();
        n_checks++;
        if (tmo || bad !== 0 || overrun !== 1'b1) begin
            n_fail++; $display("FAIL remap_new_base: got %0d bad (tmo %0b overrun %b) want 0 bad overrun 1", bad, tmo, overrun);
        end
        $display("test_remap_overrun done");
    endtask

`ifdef LEM_FONT_PAL_FETCH_EN
    task automatic test_all_regions();
        bit tmo;
        int bad;
        hwi(16'd0, 16'hF000);
        hwi(16'd1, 16'h8180);
        hwi(16'd2, 16'h8280);
        rnd_dly = 1;
        clear_stats();
        add_region(2'd0, 16'hF000, 384);
        add_region(2'd1, 16'h8180, 256);
        add_region(2'd2, 16'h8280, 16);
        start_pass();
        wait_done(1, 20000, tmo);
        rnd_dly = 0;
        bad = count_bad();
        n_checks++;
        if (tmo || bad !== 0) begin
            n_fail++; $display("FAIL all_writes: got %0d bad (n=%0d first %0d tmo %0b) want 0 of 656", bad, wr_q.size(), first_bad, tmo);
        end
        n_checks++;
        if (unstable !== 0 || pass_cnt !== 1) begin
            n_fail++; $display("FAIL all_handshake: got unstable %0d passes %0d want 0 1", unstable, pass_cnt);
        end
        hwi(16'd1, 16'h0000);
        hwi(16'd2, 16'h0000);
        $display("test_all_regions done: %0d writes", wr_q.size());
    endtask
`endif

    task automatic test_reset_mid();
        bit seen = 0;
        hwi(16'd0, 16'h2000);
        clear_stats();
        start_pass();
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge CLK); #1;
            seen = dma_req;
        end
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (!seen || {dma_req, buf_wren, busy, pass_done, overrun} !== 5'b0) begin
            n_fail++; $display("FAIL midreset_ctrl: got req_seen %b ctrl %b want 1 00000", seen, {dma_req, buf_wren, busy, pass_done, overrun});
        end
        n_checks++;
        if (dma_addr !== 16'h0 || border_colour !== 4'h0 || {buf_sel, buf_addr, buf_data} !== 27'h0) begin
            n_fail++; $display("FAIL midreset_regs: got addr %h border %h buf %h want 0", dma_addr, border_colour, {buf_sel, buf_addr, buf_data});
        end
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        clear_stats();
        repeat (12) @(negedge CLK); #1;
        n_checks++;
        if (wr_q.size() !== 0 || req_cyc !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_quiet: got writes %0d req %0d busy %b want 0 0 0", wr_q.size(), req_cyc, busy);
        end
        hwi(16'd3, 16'h001C); #1;
        n_checks++;
        if (border_colour !== 4'hC) begin
            n_fail++; $display("FAIL midreset_border: got %h want c", border_colour);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_done_overrun();
`ifndef LEM_FONT_PAL_FETCH_EN
        hwi(16'd1, 16'h8180);
`endif
        hwi(16'd7, 16'h0009);
        clear_stats();
        start_pass();
        @(negedge CLK);
        frame_start = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0;
        #1;
        n_checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL done_overrun: got overrun %b busy %b want 1 0", overrun, busy);
        end
        repeat (3) @(negedge CLK); #1;
        n_checks++;
        if (pass_cnt !== 1 || busy_cyc !== 2 || req_cyc !== 0 || border_colour !== 4'hC) begin
            n_fail++; $display("FAIL done_stats: got passes %0d busy %0d req %0d border %h want 1 2 0 c", pass_cnt, busy_cyc, req_cyc, border_colour);
        end
        $display("test_done_overrun done");
    endtask

    initial begin
        test_reset();
        test_empty_pass();
        test_screen();
        test_wrap();
        test_remap_overrun();
`ifdef LEM_FONT_PAL_FETCH_EN
        test_all_regions();
`endif
        test_reset_mid();
        test_done_overrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lem_dma_fetch.md
Name: lem_dma_fetch

Overview:
- Display-memory fetch engine sitting directly upstream of the screen controller's VRAM, font and palette buffers.
- Decodes LEM1802-style hardware-interrupt commands into base-address and border registers.
- On each frame-start pulse, walks every mapped region in DCPU RAM over a single-outstanding DMA read port and writes each returned word into the matching local buffer.
- Replaces the free-running fixed-base VRAM copy loop with a mappable, handshaked, once-per-frame refresh.

Parameters:
SCREEN_WORDS, 384, words fetched for the screen region (0x000..0x17F)
FONT_WORDS, 256, words fetched for the font region
PAL_WORDS, 16, words fetched for the palette region
ADDR_W, 16, DCPU address/data width

Ports:
CLK  in  1  single clock for all logic
RST_N  in  1  asynchronous active-low reset
hwi_valid  in  1  one-cycle strobe: HWI command present
hwi_a  in  16  command code (register A)
hwi_b  in  16  command argument (register B)
frame_start  in  1  one-cycle pulse at vertical blank start
dma_req  out  1  read request
dma_addr  out  16  read address, stable while dma_req high
dma_gnt  in  1  request accepted this cycle
dma_valid  in  1  read data valid this cycle
dma_q  in  16  read data
buf_wren  out  1  buffer write strobe
buf_sel  out  2  target buffer: 0 screen, 1 font, 2 palette
buf_addr  out  9  word index within the target buffer
buf_data  out  16  word to write
border_colour  out  4  border palette index
busy  out  1  fetch pass in progress
pass_done  out  1  one-cycle pulse when a pass completes
overrun  out  1  sticky: frame_start arrived while busy

Behaviour:
- Reset (RST_N low, asynchronous):
  - All bases cleared to 0 (region unmapped); border_colour = 0.
  - State IDLE.
  - All outputs 0.
  - Takes effect immediately, including mid-pass: dma_req drops without waiting for dma_gnt, and any pending dma_valid is ignored after release.
- HWI decode, on hwi_valid only; other codes are ignored:
  - A=0: screen_base <= B.
  - A=1: font_base <= B.
  - A=2: palette_base <= B.
  - A=3: border_colour <= B[3:0].
  - B=0 unmaps the region.
  - Registers update in the cycle after the strobe, regardless of state.
- States: IDLE, SNAP, SCREEN, FONT, PAL, DONE.
- IDLE -> SNAP on frame_start. SNAP takes one cycle: copies all three bases into shadow registers and clears the word counter. The pass uses the shadows only, so remapping mid-pass affects the next pass.
- Region order: SCREEN -> FONT -> PAL. A region whose shadow base is 0 is skipped, taking zero cycles. After PAL, go to DONE. DONE takes one cycle: pass_done = 1, then IDLE.
- busy is high in every state except IDLE.
- Per word (one outstanding request):
  - Assert dma_req with dma_addr = (shadow_base + counter) mod 2^16.
  - Hold both until a cycle with dma_gnt = 1, then drop dma_req the next cycle.
  - Wait for dma_valid (any latency ≥ 1 cycle after gnt).
  - In the cycle after dma_valid: buf_wren = 1, buf_data = dma_q, buf_addr = counter, buf_sel = region.
  - Counter increments; next request may assert in that same cycle.
  - After the last word (counter = N-1), advance to the next region and clear the counter.
- Minimum throughput: 3 cycles/word when gnt and valid each arrive in one cycle.
- dma_valid with no request outstanding is ignored.
- frame_start while busy: ignored for fetching; overrun set to 1 and held until reset.
- frame_start in the same cycle as the DONE->IDLE transition counts as busy and is treated as overrun.
- Address wrap: base FFF0 with screen fetch reads FFF0..FFFF, then 0000..016F.

Optional Feature:
- Macro LEM_FONT_PAL_FETCH_EN.
- Defined: behaviour as above.
- Undefined:
  - FONT and PAL states, font/palette base and shadow registers are removed.
  - A=1 and A=2 are ignored.
  - buf_sel is tied to 0.
  - A pass is SNAP -> SCREEN -> DONE.

Test Plan:
- Reset only, frame_start pulsed -> SNAP then DONE: pass_done after 2 cycles, no dma_req, busy high for exactly those 2 cycles, border_colour = 0.
- HWI A=0 B=F000; gnt/valid each 1 cycle after; frame_start -> 384 reads F000..F17F, buf_addr 0..17F, buf_sel 0, buf_data = dma_q; pass_done once.
- Screen F000, font 8180, palette 8280, random gnt/valid delays 1-5 cycles -> 384+256+16 writes in order screen, font, palette; dma_addr stable while dma_req high and ungranted.
- Screen base FFF0 -> addresses FFF0..FFFF, 0000..016F; buf_addr continuous 0..17F.
- Mid-pass HWI A=0 B=A000 and frame_start -> current pass stays on the old base, overrun = 1; the next pass reads A000.
- RST_N low mid-screen-fetch with dma_req high -> all outputs 0 immediately; after release, HWI A=3 B=0x001C gives border_colour = 0xC.
